// File: rtl/dmem_copy_engine_pkg.sv
// rtl/dmem_copy_engine_pkg.sv - shared constants and FSM encoding for the data-memory copy engine
// Contents: SIGN_MASK_WORD, WORD_BYTES, state_e (8 states, 3 bits).
package dmem_copy_engine_pkg;

    localparam logic [3:0] SIGN_MASK_WORD = 4'b0110;
    localparam int         WORD_BYTES     = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_WHI = 3'd2,
        S_RD_WLO = 3'd3,
        S_WR_REQ = 3'd4,
        S_WR_WHI = 3'd5,
        S_WR_WLO = 3'd6,
        S_FIN    = 3'd7
    } state_e;

endpackage

// File: rtl/dmem_copy_engine_stall_watchdog.sv
// rtl/dmem_copy_engine_stall_watchdog.sv - bounded wait counter for one clk_stall edge
// Ports: clk, reset (sync, active-high), clear (restart count), arm (waiting),
//        expired (high in the TIMEOUT-th consecutive armed cycle).
module dmem_copy_engine_stall_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic arm,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Count 0 in the first armed cycle, so expiry lands on the TIMEOUT-th wait cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (arm && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = arm && (cnt_q == LAST);

endmodule

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - data-memory port initiator that copies (or fills) a block of words
// Ports: clk, reset (sync, active-high); start + cfg_src/cfg_dst/cfg_len/cfg_fill/cfg_pattern;
//        busy/done/error status; mem_addr/mem_write_data/mem_memwrite/mem_memread/mem_sign_mask
//        to data memory; mem_read_data/mem_clk_stall from data memory.
// Optional feature: DMEM_COPY_FILL_EN enables fill mode (cfg_fill/cfg_pattern).
module dmem_copy_engine
    import dmem_copy_engine_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      cfg_src,
    input  logic [31:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_fill,
    input  logic [31:0]      cfg_pattern,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_memwrite,
    output logic             mem_memread,
    output logic [3:0]       mem_sign_mask,
    input  logic [31:0]      mem_read_data,
    input  logic             mem_clk_stall
);

    localparam logic [31:0] STEP = 32'(WORD_BYTES);

    state_e           state_q;
    logic [31:0]      src_q, dst_q;
    logic [LEN_W-1:0] len_q;
    logic             fill_q;
    logic             busy_q, done_q, error_q, rd_q, wr_q;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       mask_q;

    logic fill_req, misalign, in_wait, stall_edge, wd_clear, wd_expired;

`ifdef DMEM_COPY_FILL_EN
    assign fill_req = cfg_fill;
`else
    logic unused_cfg_fill;
    assign unused_cfg_fill = cfg_fill;
    assign fill_req        = 1'b0;
`endif

    // Source alignment only matters when it will actually be read.
    assign misalign = (cfg_dst[1:0] != 2'b00) || (!fill_req && (cfg_src[1:0] != 2'b00));

    assign in_wait    = state_q inside {S_RD_WHI, S_RD_WLO, S_WR_WHI, S_WR_WLO};
    assign stall_edge = ((state_q == S_RD_WHI || state_q == S_WR_WHI) &&  mem_clk_stall) ||
                        ((state_q == S_RD_WLO || state_q == S_WR_WLO) && !mem_clk_stall);
    // Restart the wait count whenever a wait state is (re)entered.
    assign wd_clear   = !in_wait || stall_edge;

    dmem_copy_engine_stall_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .arm     (in_wait),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            mask_q <= SIGN_MASK_WORD;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            if (wd_expired && !stall_edge) begin
                // Abort: remaining words are abandoned.
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !mem_clk_stall) begin
                            src_q   <= cfg_src;
                            dst_q   <= cfg_dst;
                            len_q   <= cfg_len;
                            fill_q  <= fill_req;
                            error_q <= 1'b0;
                            if (misalign) begin
                                error_q <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end else if (cfg_len == '0) begin
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end else if (fill_req) begin
                                busy_q  <= 1'b1;
                                wr_q    <= 1'b1;
                                addr_q  <= cfg_dst;
                                wdata_q <= cfg_pattern;
                                state_q <= S_WR_REQ;
                            end else begin
                                busy_q  <= 1'b1;
                                rd_q    <= 1'b1;
                                addr_q  <= cfg_src;
                                state_q <= S_RD_REQ;
                            end
                        end
                    end
                    S_RD_REQ: state_q <= S_RD_WHI;
                    S_RD_WHI: if (mem_clk_stall) state_q <= S_RD_WLO;
                    S_RD_WLO: begin
                        if (!mem_clk_stall) begin
                            // The read word doubles as the write data latch.
                            wdata_q <= mem_read_data;
                            wr_q    <= 1'b1;
                            addr_q  <= dst_q;
                            state_q <= S_WR_REQ;
                        end
                    end
                    S_WR_REQ: state_q <= S_WR_WHI;
                    S_WR_WHI: if (mem_clk_stall) state_q <= S_WR_WLO;
                    S_WR_WLO: begin
                        if (!mem_clk_stall) begin
                            src_q <= src_q + STEP;
                            dst_q <= dst_q + STEP;
                            len_q <= len_q - LEN_W'(1);
                            if (len_q == LEN_W'(1)) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end else if (fill_q) begin
                                wr_q    <= 1'b1;
                                addr_q  <= dst_q + STEP;
                                state_q <= S_WR_REQ;
                            end else begin
                                rd_q    <= 1'b1;
                                addr_q  <= src_q + STEP;
                                state_q <= S_RD_REQ;
                            end
                        end
                    end
                    S_FIN:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_memwrite   = wr_q;
    assign mem_memread    = rd_q;
    assign mem_sign_mask  = mask_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - self-checking bench for dmem_copy_engine with a 2-cycle-stall memory responder
module tb_dmem_copy_engine;

    localparam int LEN_W   = 10;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      cfg_src = '0;
    logic [31:0]      cfg_dst = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_fill = 1'b0;
    logic [31:0]      cfg_pattern = '0;
    logic             busy, done, error;
    logic [31:0]      mem_addr, mem_write_data;
    logic             mem_memwrite, mem_memread;
    logic [3:0]       mem_sign_mask;
    logic [31:0]      mem_read_data = 32'hBAD0BAD0;
    logic             mem_clk_stall = 1'b0;

    always #5 clk = ~clk;

    dmem_copy_engine #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_src        (cfg_src),
        .cfg_dst        (cfg_dst),
        .cfg_len        (cfg_len),
        .cfg_fill       (cfg_fill),
        .cfg_pattern    (cfg_pattern),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
        end
    endtask

    // Memory responder: request seen in cycle T, stall high T+1..T+2, low with data in T+3.
    logic [31:0] mem [logic [31:0]];
    bit          no_stall = 1'b0;
    int          ph = 0;
    logic [31:0] r_addr = '0;
    logic [31:0] r_wdata = '0;
    bit          r_wr = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ph)
            0: begin
                mem_read_data = 32'hBAD0BAD0;
                if (mem_memread || mem_memwrite) begin
                    r_addr  = mem_addr;
                    r_wdata = mem_write_data;
                    r_wr    = mem_memwrite;
                    ph      = 1;
                end
            end
            1: begin
                mem_clk_stall = !no_stall;
                ph = 2;
            end
            2: ph = 3;
            default: begin
                mem_clk_stall = 1'b0;
                if (r_wr) mem[r_addr] = r_wdata;
                else      mem_read_data = mem_rd(r_addr);
                ph = 0;
            end
        endcase
    end

    // Reference model: expected bus requests and memory image.
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Bus compare process.
    bit   prev_req = 1'b0;
    req_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (mem_memread || mem_memwrite) begin
                chk("req_single_cycle", 32'(prev_req), 32'h0);
                chk("req_exclusive", 32'(mem_memread && mem_memwrite), 32'h0);
                chk("sign_mask", 32'(mem_sign_mask), 32'h6);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got wr=%0d addr=0x%08h expected no request", mem_memwrite, mem_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("req_kind", 32'(mem_memwrite), 32'(mon_e.wr));
                    chk("req_addr", mem_addr, mon_e.addr);
                    if (mon_e.wr) chk("req_wdata", mem_write_data, mon_e.data);
                end
            end
            prev_req = mem_memread || mem_memwrite;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_done"},  32'(done), 32'h0);
        chk({tag, "_error"}, 32'(error), 32'h0);
        chk({tag, "_rd"},    32'(mem_memread), 32'h0);
        chk({tag, "_wr"},    32'(mem_memwrite), 32'h0);
        chk({tag, "_addr"},  mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_write_data, 32'h0);
        chk({tag, "_mask"},  32'(mem_sign_mask), 32'h0);
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input bit fill, input logic [31:0] pat, input bit to,
                            output int busy_o);
        bit          fill_eff, mis, got_done;
        int          exp_busy, busy_n, lat;
        logic [31:0] w;
`ifdef DMEM_COPY_FILL_EN
        fill_eff = fill;
`else
        fill_eff = 1'b0;
`endif
        mis = (dst[1:0] != 2'b00) || (!fill_eff && (src[1:0] != 2'b00));
        if (!mis && len > 0) begin
            if (to) begin
                if (fill_eff) exp_q.push_back('{1'b1, dst, pat});
                else          exp_q.push_back('{1'b0, src, 32'h0});
            end else begin
                for (int i = 0; i < len; i++) begin
                    if (fill_eff) begin
                        w = pat;
                    end else begin
                        w = ref_rd(src + 32'(4 * i));
                        exp_q.push_back('{1'b0, src + 32'(4 * i), 32'h0});
                    end
                    exp_q.push_back('{1'b1, dst + 32'(4 * i), w});
                    ref_mem[dst + 32'(4 * i)] = w;
                end
            end
        end
        if (mis || len == 0) exp_busy = 0;
        else if (to)         exp_busy = 1 + TIMEOUT;
        else                 exp_busy = len * (fill_eff ? 4 : 8);

        @(negedge clk);
        start = 1'b1; cfg_src = src; cfg_dst = dst; cfg_len = LEN_W'(len);
        cfg_fill = fill; cfg_pattern = pat;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_error_on_accept"}, 32'(error), 32'(mis));
        busy_n = 0; lat = 0; got_done = 1'b0;
        for (int c = 1; c <= 400 && !got_done; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                got_done = 1'b1;
                lat = c;
            end
        end
        chk({tag, "_done_seen"}, 32'(got_done), 32'h1);
        chk({tag, "_busy_cycles"}, busy_n, exp_busy);
        chk({tag, "_done_latency"}, lat, exp_busy + 1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'h0);
        chk({tag, "_error_at_done"}, 32'(error), 32'(mis || to));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'h0);
        chk({tag, "_error_sticky"}, 32'(error), 32'(mis || to));
        chk({tag, "_all_requests"}, exp_q.size(), 0);
        exp_q.delete();
        if (!mis && !to) begin
            for (int i = 0; i < len; i++)
                chk({tag, "_dst_word"}, mem_rd(dst + 32'(4 * i)), ref_rd(dst + 32'(4 * i)));
        end
        busy_o = busy_n;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          bn;
        bit          found;
        logic [31:0] init_v [4];
        init_v[0] = 32'h11111111; init_v[1] = 32'h22222222;
        init_v[2] = 32'h33333333; init_v[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            mem[32'h1000 + 32'(4 * i)]     = init_v[i];
            ref_mem[32'h1000 + 32'(4 * i)] = init_v[i];
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic 4-word copy.
        run_xfer("copy4", 32'h1000, 32'h1100, 4, 1'b0, 32'h0, 1'b0, bn);
        chk("copy4_busy_lit", bn, 32);
        chk("copy4_w0_lit", mem_rd(32'h1100), 32'h11111111);
        chk("copy4_w1_lit", mem_rd(32'h1104), 32'h22222222);
        chk("copy4_w2_lit", mem_rd(32'h1108), 32'h33333333);
        chk("copy4_w3_lit", mem_rd(32'h110C), 32'h44444444);

        // Zero length, misalignment and recovery.
        run_xfer("len0", 32'h1000, 32'h1180, 0, 1'b0, 32'h0, 1'b0, bn);
        run_xfer("mis_src", 32'h1002, 32'h1180, 2, 1'b0, 32'h0, 1'b0, bn);
        run_xfer("after_mis", 32'h1004, 32'h1180, 1, 1'b0, 32'h0, 1'b0, bn);
        chk("after_mis_lit", mem_rd(32'h1180), 32'h22222222);
        run_xfer("mis_dst", 32'h1000, 32'h1181, 1, 1'b0, 32'h0, 1'b0, bn);
        run_xfer("same_addr", 32'h1100, 32'h1100, 2, 1'b0, 32'h0, 1'b0, bn);

        // Responder never stalls: abort after TIMEOUT wait cycles.
        no_stall = 1'b1;
        run_xfer("timeout", 32'h1000, 32'h1300, 3, 1'b0, 32'h0, 1'b1, bn);
        chk("timeout_busy_lit", bn, 16);
        repeat (20) @(negedge clk);
        no_stall = 1'b0;
        chk("timeout_no_write", mem_rd(32'h1300), 32'h0);

        // Reset during RD_WHI of word 2.
        exp_q.push_back('{1'b0, 32'h1000, 32'h0});
        exp_q.push_back('{1'b1, 32'h1400, 32'h11111111});
        exp_q.push_back('{1'b0, 32'h1004, 32'h0});
        ref_mem[32'h1400] = 32'h11111111;
        @(negedge clk);
        start = 1'b1; cfg_src = 32'h1000; cfg_dst = 32'h1400; cfg_len = LEN_W'(4); cfg_fill = 1'b0;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (mem_memread && mem_addr == 32'h1004) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_word2_read_seen", 32'(found), 32'h1);
        @(negedge clk);
        chk("rst_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("rst_mid");
        chk("rst_requests_before", exp_q.size(), 0);
        exp_q.delete();
        exp_q.push_back('{1'b0, 32'h1000, 32'h0});
        exp_q.push_back('{1'b1, 32'h1500, 32'h11111111});
        ref_mem[32'h1500] = 32'h11111111;
        start = 1'b1; cfg_dst = 32'h1500; cfg_len = LEN_W'(1);
        @(negedge clk);
        chk("rst_start_ignored", 32'(busy), 32'h0);
        @(negedge clk);
        start = 1'b0;
        chk("rst_start_accepted", 32'(busy), 32'h1);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (done) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_after_done", 32'(found), 32'h1);
        @(negedge clk);
        chk("rst_after_requests", exp_q.size(), 0);
        exp_q.delete();
        chk("rst_after_word", mem_rd(32'h1500), 32'h11111111);

        // Fill (copy from cfg_src when fill support is not built).
        run_xfer("fill3", 32'h1000, 32'h1200, 3, 1'b1, 32'hDEADBEEF, 1'b0, bn);
`ifdef DMEM_COPY_FILL_EN
        chk("fill3_busy_lit", bn, 12);
        chk("fill3_w0_lit", mem_rd(32'h1200), 32'hDEADBEEF);
        chk("fill3_w2_lit", mem_rd(32'h1208), 32'hDEADBEEF);
`else
        chk("fill3_busy_lit", bn, 24);
        chk("fill3_w0_lit", mem_rd(32'h1200), 32'h11111111);
        chk("fill3_w2_lit", mem_rd(32'h1208), 32'h33333333);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
